// File: rtl/truth_table_checker_pkg.sv
// Shared types and constants for the truth-table checker.
// FSM encoding, default AND3 vector, settle-time floor.
package truth_table_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam logic [7:0] AND3_TT = 8'h80;

  // 2 synchronizer flops plus one cycle of cell settling
  localparam int SETTLE_MIN = 3;

endpackage

// File: rtl/truth_table_checker_if.sv
// Control/result bundle between a sweep requester and the checker.
// The master requests sweeps; the slave reports results.
interface truth_table_checker_if #(
  parameter int N_IN = 3
);

  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [2**N_IN-1:0]   resp_vec;
  logic [N_IN:0]        err_count;
  logic                 first_fail_valid;
  logic [N_IN-1:0]      first_fail_idx;

  modport master (
    output start,
    input  busy,
    input  done,
    input  pass,
    input  resp_vec,
    input  err_count,
    input  first_fail_valid,
    input  first_fail_idx
  );

  modport slave (
    input  start,
    output busy,
    output done,
    output pass,
    output resp_vec,
    output err_count,
    output first_fail_valid,
    output first_fail_idx
  );

endinterface

// File: rtl/truth_table_checker_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Output resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive-stimulus engine: sweeps all input patterns of a cell,
// samples its synchronized output and compares against EXPECTED.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int                 N_IN       = 3,
  parameter int                 SETTLE_CYC = 4,
  parameter logic [2**N_IN-1:0] EXPECTED   = AND3_TT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  truth_table_checker_if.slave    ctl,
  output logic [N_IN-1:0]         x_out,
  input  logic                    y_in
);

  localparam int NP = 2**N_IN;
  localparam int CW = $clog2(SETTLE_CYC);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NP - 1);
  localparam logic [CW-1:0]   CNT_END  = CW'(SETTLE_CYC - 1);

  if (SETTLE_CYC < SETTLE_MIN) begin : g_settle_chk
    $error("SETTLE_CYC below synchronizer latency plus settling");
  end

  state_e            state_q, state_d;
  logic [N_IN-1:0]   idx_q,   idx_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic [N_IN-1:0]   x_q,     x_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic [NP-1:0]     resp_q,  resp_d;
  logic [N_IN:0]     err_q,   err_d;
  logic              ffv_q,   ffv_d;
  logic [N_IN-1:0]   ffi_q,   ffi_d;
  logic              y_s;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (y_in),
    .q_o   (y_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      resp_q  <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    busy_d  = busy_q;
    done_d  = done_q;
    resp_d  = resp_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (ctl.start) begin
          state_d = ST_SETTLE;
          idx_d   = '0;
          cnt_d   = '0;
          x_d     = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          resp_d  = '0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffi_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_END) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        resp_d[idx_q] = y_s;
        if (y_s != EXPECTED[idx_q]) begin
          err_d = err_q + 1'b1;
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          // x_out only moves here, on SETTLE entry
          state_d = ST_SETTLE;
          idx_d   = idx_q + 1'b1;
          x_d     = idx_q + 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign x_out                = x_q;
  assign ctl.busy             = busy_q;
  assign ctl.done             = done_q;
  assign ctl.pass             = done_q && (err_q == '0);
  assign ctl.resp_vec         = resp_q;
  assign ctl.err_count        = err_q;
  assign ctl.first_fail_valid = ffv_q;
  assign ctl.first_fail_idx   = ffi_q;

endmodule
